ipg_rx_arbiter: RTL and testbench

- Sits after the IPG receive extractor in the 10G PHY RX path.
- Takes three one-cycle-pulse request classes (write request, read request, read response), each carrying a shared 6-bit length and 64-bit payload.
- Buffers each class in its own FIFO and arbitrates them onto a single valid/ready output stream toward the memory/host side.
- Arbitration: read responses have priority, bounded by a starvation guard; the two request classes are round-robin.

---
 rtl/ipg_rx_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_ipg_rx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipg_rx_arbiter.sv
// ipg_rx_arbiter: buffers the three IPG receive classes (write request,
// read request, read response) in per-class FIFOs and arbitrates them onto
// one valid/ready beat stream. Read responses win, limited by a streak
// guard so requests are not starved; the two request classes alternate.
module ipg_rx_arbiter #(
  parameter int QDEPTH         = 4,
  parameter int MAX_RESP_BURST = 4,
  parameter int DATA_WIDTH     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wreq_valid,
  input  logic                  rreq_valid,
  input  logic                  rresp_valid,
  input  logic [5:0]            rx_len,
  input  logic [DATA_WIDTH-1:0] rx_ipg_data,
  input  logic                  arb_enable,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            m_type,
  output logic [5:0]            m_len,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [7:0]            drop_count,
  output logic [2:0]            overflow,
  output logic                  collision
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = $clog2(MAX_RESP_BURST + 1);
  localparam int EW = 6 + DATA_WIDTH;

  localparam logic [1:0] CLS_WREQ  = 2'd0;
  localparam logic [1:0] CLS_RREQ  = 2'd1;
  localparam logic [1:0] CLS_RRESP = 2'd2;

  // Per-class FIFO state; class index 0 = wreq, 1 = rreq, 2 = rresp.
  logic [EW-1:0] mem_q  [3][QDEPTH];
  logic [AW-1:0] rptr_q [3];
  logic [AW-1:0] wptr_q [3];
  logic [CW-1:0] cnt_q  [3];

  // Arbitration state: round-robin pointer (0 = wreq next, 1 = rreq next)
  // and the count of consecutive response grants.
  logic          rr_q;
  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;

  // Output register.
  logic                  m_valid_q;
  logic [1:0]            m_type_q;
  logic [5:0]            m_len_q;
  logic [DATA_WIDTH-1:0] m_data_q;

  // Sticky status.
  logic [7:0] drop_q;
  logic [7:0] drop_d;
  logic [2:0] ovf_q;
  logic [2:0] ovf_d;
  logic       coll_q;
  logic       coll_d;

  // Combinational arbitration / enqueue signals.
  logic [2:0]    ne;
  logic          req_any;
  logic          any_ne;
  logic          resp_win;
  logic [1:0]    gnt;
  logic          load;
  logic [2:0]    pop;
  logic [2:0]    full;
  logic [2:0]    push;
  logic [2:0]    pv;
  logic          pulse_any;
  logic [1:0]    nv;
  logic [1:0]    win;
  logic          full_drop;
  logic          coll_set;
  logic [1:0]    drop_inc;
  logic [8:0]    drop_sum;
  logic [EW-1:0] head;

  assign ne[0]    = (cnt_q[0] != '0);
  assign ne[1]    = (cnt_q[1] != '0);
  assign ne[2]    = (cnt_q[2] != '0);
  assign req_any  = ne[0] | ne[1];
  assign any_ne   = |ne;

  // A response may keep winning until its streak hits the limit, unless no
  // request is waiting, in which case it wins regardless.
  assign resp_win = ne[2] && ((streak_q < SW'(MAX_RESP_BURST)) || !req_any);

  // Flush empties the FIFOs on the same edge, so nothing is loaded then.
  assign load = (!m_valid_q || m_ready) && arb_enable && any_ne && !flush;

  // Pick the grantee: response first, else the round-robin request class.
  always_comb begin
    gnt = CLS_WREQ;
    if (resp_win) begin
      gnt = CLS_RRESP;
    end else if (ne[{1'b0, rr_q}]) begin
      gnt = {1'b0, rr_q};
    end else begin
      gnt = {1'b0, ~rr_q};
    end
  end

  // Head-of-queue entry of the grantee.
  always_comb begin
    case (gnt)
      CLS_RREQ:  head = mem_q[1][rptr_q[1]];
      CLS_RRESP: head = mem_q[2][rptr_q[2]];
      default:   head = mem_q[0][rptr_q[0]];
    endcase
  end

  // Decide which pulse is enqueued and what gets dropped this cycle.
  always_comb begin
    pv        = {rresp_valid, rreq_valid, wreq_valid};
    pulse_any = |pv;
    nv        = 2'(pv[0]) + 2'(pv[1]) + 2'(pv[2]);
    win       = CLS_WREQ;
    if (pv[2]) begin
      win = CLS_RRESP;
    end else if (pv[1]) begin
      win = CLS_RREQ;
    end
    pop  = '0;
    full = '0;
    push = '0;
    for (int c = 0; c < 3; c++) begin
      pop[c]  = load && (gnt == 2'(c));
      // A full FIFO that pops on this edge still has room for the push.
      full[c] = (cnt_q[c] == CW'(QDEPTH)) && !pop[c];
      push[c] = !flush && pulse_any && (win == 2'(c)) && !full[c];
    end
    full_drop = !flush && pulse_any && full[win];
    coll_set  = !flush && (nv > 2'd1);
    drop_inc  = '0;
    if (!flush && pulse_any) begin
      drop_inc = (nv - 2'd1) + 2'(full_drop);
    end
    drop_sum = {1'b0, drop_q} + 9'(drop_inc);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    ovf_d    = ovf_q | (full_drop ? (3'b001 << win) : 3'b000);
    coll_d   = coll_q | coll_set;
  end

  // Response streak saturates; any request grant restarts it.
  always_comb begin
    streak_d = streak_q;
    if (load) begin
      if (gnt == CLS_RRESP) begin
        if (streak_q != SW'(MAX_RESP_BURST)) begin
          streak_d = streak_q + SW'(1);
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  // FIFO pointers and occupancy; flush empties every class at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        rptr_q[c] <= '0;
        wptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else if (flush) begin
      for (int c = 0; c < 3; c++) begin
        rptr_q[c] <= '0;
        wptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (push[c]) begin
          wptr_q[c] <= wptr_q[c] + AW'(1);
        end
        if (pop[c]) begin
          rptr_q[c] <= rptr_q[c] + AW'(1);
        end
        cnt_q[c] <= cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (push[c]) begin
        mem_q[c][wptr_q[c]] <= {rx_len, rx_ipg_data};
      end
    end
  end

  // Output beat register: loads from the grantee, otherwise drains on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_type_q  <= '0;
      m_len_q   <= '0;
      m_data_q  <= '0;
    end else if (load) begin
      m_valid_q <= 1'b1;
      m_type_q  <= gnt;
      m_len_q   <= head[EW-1:DATA_WIDTH];
      m_data_q  <= head[DATA_WIDTH-1:0];
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Arbitration state: round-robin pointer moves past the granted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
      if (load && (gnt != CLS_RRESP)) begin
        rr_q <= (gnt == CLS_WREQ);
      end
    end
  end

  // Sticky drop/overflow/collision status, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      ovf_q  <= '0;
      coll_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
      coll_q <= coll_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_type     = m_type_q;
  assign m_len      = m_len_q;
  assign m_data     = m_data_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;
  assign collision  = coll_q;

endmodule

// File: tb/tb_ipg_rx_arbiter.sv
// Testbench for ipg_rx_arbiter: queue-based reference model with a
// scoreboard of expected output beats, directed scenarios plus random traffic.
module tb_ipg_rx_arbiter;

  localparam int QD  = 4;
  localparam int MRB = 4;
  localparam int DW  = 64;

  logic          clk;
  logic          rst_n;
  logic          wreq_valid, rreq_valid, rresp_valid;
  logic [5:0]    rx_len;
  logic [DW-1:0] rx_ipg_data;
  logic          arb_enable, flush;
  logic          m_valid, m_ready;
  logic [1:0]    m_type;
  logic [5:0]    m_len;
  logic [DW-1:0] m_data;
  logic [7:0]    drop_count;
  logic [2:0]    overflow;
  logic          collision;

  ipg_rx_arbiter #(.QDEPTH(QD), .MAX_RESP_BURST(MRB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wreq_valid(wreq_valid), .rreq_valid(rreq_valid), .rresp_valid(rresp_valid),
    .rx_len(rx_len), .rx_ipg_data(rx_ipg_data),
    .arb_enable(arb_enable), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_type(m_type), .m_len(m_len), .m_data(m_data),
    .drop_count(drop_count), .overflow(overflow), .collision(collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [69:0] q0[$], q1[$], q2[$];
  logic [71:0] sbq[$];
  int          m_mv, streak, rr, m_drop;
  logic [2:0]  m_ovf;
  logic        m_coll;

  function automatic int msize(input int c);
    case (c)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic mpush(input int c, input logic [69:0] e);
    case (c)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mpop(input int c, output logic [69:0] e);
    case (c)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete(); sbq.delete();
    m_mv = 0; streak = 0; rr = 0; m_drop = 0; m_ovf = '0; m_coll = 1'b0;
  endtask

  // One clock edge of the model, using the inputs presented to that edge.
  task automatic model_step();
    int sz[3];
    int g, nv, w;
    bit ld;
    logic [69:0] e;
    for (int c = 0; c < 3; c++) sz[c] = msize(c);
    ld = (m_mv == 0 || m_ready) && arb_enable && (sz[0] + sz[1] + sz[2] > 0) && !flush;
    if (ld) begin
      if (sz[2] > 0 && (streak < MRB || (sz[0] == 0 && sz[1] == 0))) begin
        g = 2;
        if (streak < MRB) streak++;
      end else begin
        g = (sz[rr] > 0) ? rr : 1 - rr;
        rr = 1 - g;
        streak = 0;
      end
      mpop(g, e);
      sbq.push_back({2'(g), e});
      m_mv = 1;
    end else if (m_ready) begin
      m_mv = 0;
    end
    if (flush) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      nv = int'(wreq_valid) + int'(rreq_valid) + int'(rresp_valid);
      if (nv > 0) begin
        w = rresp_valid ? 2 : (rreq_valid ? 1 : 0);
        if (nv > 1) m_coll = 1'b1;
        m_drop += nv - 1;
        if (msize(w) >= QD) begin
          m_drop++;
          m_ovf[w] = 1'b1;
        end else begin
          mpush(w, {rx_len, rx_ipg_data});
        end
        if (m_drop > 255) m_drop = 255;
      end
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc_cnt = 0;
  logic [1:0] acc_type[$];
  logic [5:0] acc_len[$];
  int         acc_cyc[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    logic [71:0] exp;
    if (rst_n) begin
      chk("m_valid", 72'(m_valid), 72'(m_mv));
      if (m_valid && m_ready) begin
        acc_type.push_back(m_type);
        acc_len.push_back(m_len);
        acc_cyc.push_back(cyc_cnt);
        if (sbq.size() == 0) begin
          chk("beat_unexpected", {m_type, m_len, m_data}, 72'h0);
          checks = checks; // keep counters consistent for an unexpected zero beat
          if ({m_type, m_len, m_data} === 72'h0) begin
            errors++;
            $display("FAIL beat_unexpected actual=0 required=none at %0t", $time);
          end
        end else begin
          exp = sbq.pop_front();
          chk("beat", {m_type, m_len, m_data}, exp);
        end
      end
      chk("drop_count", 72'(drop_count), 72'(m_drop));
      chk("overflow", 72'(overflow), 72'(m_ovf));
      chk("collision", 72'(collision), 72'(m_coll));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    wreq_valid = 1'b0; rreq_valid = 1'b0; rresp_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic pulse(input bit w, input bit r, input bit s,
                       input logic [5:0] len, input logic [63:0] d);
    wreq_valid = w; rreq_valid = r; rresp_valid = s;
    rx_len = len; rx_ipg_data = d;
    tick();
  endtask

  task automatic clear_log();
    acc_type.delete(); acc_len.delete(); acc_cyc.delete();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_m_valid", 72'(m_valid), 72'h0);
    chk("rst_m_bits", {m_type, m_len, m_data}, 72'h0);
    chk("rst_drop", 72'(drop_count), 72'h0);
    chk("rst_ovf", 72'(overflow), 72'h0);
    chk("rst_coll", 72'(collision), 72'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic drain();
    int i;
    arb_enable = 1'b1; m_ready = 1'b1;
    i = 0;
    while (i < 64 && (q0.size() + q1.size() + q2.size() + m_mv) > 0) begin
      tick();
      i++;
    end
    tick();
    chk("drain_bound", 72'(q0.size() + q1.size() + q2.size() + m_mv), 72'h0);
    chk("sb_empty", 72'(sbq.size()), 72'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_t[];
    rst_n = 1'b0;
    wreq_valid = 0; rreq_valid = 0; rresp_valid = 0;
    rx_len = '0; rx_ipg_data = '0;
    arb_enable = 0; flush = 0; m_ready = 0;
    model_reset();
    #12;

    // Single beat and latency
    do_reset();
    arb_enable = 1; m_ready = 1;
    pulse(1, 0, 0, 6'd8, 64'h1122334455667788);
    chk("lat_cycle1", 72'(m_valid), 72'h0);
    tick();
    chk("lat_cycle2", 72'(m_valid), 72'h1);
    chk("single_type", 72'(m_type), 72'h0);
    chk("single_len", 72'(m_len), 72'd8);
    chk("single_data", 72'(m_data), 72'h1122334455667788);
    tick();
    chk("single_one_cycle", 72'(m_valid), 72'h0);

    // Backpressure and no-bubble drain
    do_reset();
    arb_enable = 1; m_ready = 0;
    for (int i = 1; i <= 3; i++) pulse(0, 1, 0, 6'(i), {$urandom, $urandom});
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid", 72'(m_valid), 72'h1);
      chk("bp_hold_len", 72'(m_len), 72'd1);
      tick();
    end
    clear_log();
    m_ready = 1;
    repeat (4) tick();
    chk("bp_count", 72'(acc_len.size()), 72'd3);
    for (int i = 0; i < acc_len.size(); i++) begin
      chk("bp_len", 72'(acc_len[i]), 72'(i + 1));
      if (i > 0) chk("bp_no_bubble", 72'(acc_cyc[i] - acc_cyc[i-1]), 72'd1);
    end

    // Overflow
    do_reset();
    arb_enable = 1; m_ready = 0;
    for (int i = 1; i <= 6; i++) pulse(1, 0, 0, 6'(i), {$urandom, $urandom});
    tick();
    chk("ovf_drop", 72'(drop_count), 72'd1);
    chk("ovf_flags", 72'(overflow), 72'b001);
    clear_log();
    m_ready = 1;
    repeat (8) tick();
    chk("ovf_beats", 72'(acc_len.size()), 72'd5);
    for (int i = 0; i < acc_len.size(); i++) chk("ovf_order", 72'(acc_len[i]), 72'(i + 1));

    // Starvation guard
    do_reset();
    arb_enable = 0; m_ready = 1;
    for (int i = 0; i < 4; i++) pulse(0, 0, 1, 6'(10 + i), {$urandom, $urandom});
    for (int i = 0; i < 2; i++) pulse(1, 0, 0, 6'(20 + i), {$urandom, $urandom});
    clear_log();
    arb_enable = 1;
    for (int i = 0; i < 4; i++) pulse(0, 0, 1, 6'(30 + i), {$urandom, $urandom});
    repeat (8) tick();
    exp_t = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    chk("starve_count", 72'(acc_type.size()), 72'd10);
    for (int i = 0; i < acc_type.size() && i < 10; i++) chk("starve_order", 72'(acc_type[i]), 72'(exp_t[i]));
    chk("starve_drop", 72'(drop_count), 72'h0);

    // Round-robin then collision
    do_reset();
    arb_enable = 0; m_ready = 1;
    pulse(1, 0, 0, 6'd1, 64'hA1);
    pulse(1, 0, 0, 6'd2, 64'hA2);
    pulse(0, 1, 0, 6'd3, 64'hB1);
    pulse(0, 1, 0, 6'd4, 64'hB2);
    clear_log();
    arb_enable = 1;
    repeat (6) tick();
    exp_t = '{2'd0, 2'd1, 2'd0, 2'd1};
    chk("rr_count", 72'(acc_type.size()), 72'd4);
    for (int i = 0; i < acc_type.size() && i < 4; i++) chk("rr_order", 72'(acc_type[i]), 72'(exp_t[i]));
    chk("coll_before", 72'(collision), 72'h0);
    clear_log();
    pulse(1, 0, 1, 6'd9, 64'hC0FFEE);
    repeat (4) tick();
    chk("coll_count", 72'(acc_type.size()), 72'd1);
    if (acc_type.size() > 0) chk("coll_type", 72'(acc_type[0]), 72'd2);
    chk("coll_flag", 72'(collision), 72'h1);
    chk("coll_drop", 72'(drop_count), 72'h1);

    // Asynchronous reset mid-operation
    do_reset();
    arb_enable = 1; m_ready = 0;
    for (int i = 1; i <= 6; i++) pulse(1, 0, 0, 6'(i), {$urandom, $urandom});
    chk("pre_rst_valid", 72'(m_valid), 72'h1);
    chk("pre_rst_drop", 72'(drop_count), 72'h1);
    do_reset();
    arb_enable = 1; m_ready = 1;
    repeat (8) tick();
    chk("post_rst_beats", 72'(acc_type.size()), 72'h0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      arb_enable  = ($urandom_range(7) != 0);
      m_ready     = ($urandom_range(3) != 0);
      flush       = ($urandom_range(63) == 0);
      wreq_valid  = ($urandom_range(3) == 0);
      rreq_valid  = ($urandom_range(3) == 0);
      rresp_valid = ($urandom_range(2) == 0);
      rx_len      = 6'($urandom);
      rx_ipg_data = {$urandom, $urandom};
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
